// File: rtl/uart_rx_frame.sv
// UART receive framer: start, DWIDTH data bits LSB-first, optional parity, stop; UART_RX_MAJORITY_VOTE_EN enables 2-of-3 bit voting.
// Latency: stop-bit edge on rx_in to data_valid/error pulse = 2 + OVERSAMPLE/2 + 1 clk cycles.
// Backpressure: none; the consumer must accept each 1-cycle pulse as it occurs.
module uart_rx_frame #(
    parameter int DWIDTH     = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              parity_en,
    input  logic              parity_type,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              parity_error,
    output logic              stop_error,
    output logic              busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [TW-1:0] T_SAMPLE = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(DWIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              par_en_q, par_en_d;
    logic              par_type_q, par_type_d;
    logic [DWIDTH-1:0] dout_d;
    logic              dv_d, pe_d, se_d;
    logic              rx_s1, rxs, rxs_d;
    logic              bit_val, sample, bit_end, par_exp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rxs   <= rx_s1;
            rxs_d <= rxs;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // rx_s1 holds the value rxs will take next cycle, so the vote window
    // S-1/S/S+1 is complete at tick S and decision timing is unchanged.
    assign bit_val = (rxs_d & rxs) | (rxs & rx_s1) | (rxs_d & rx_s1);
`else
    assign bit_val = rxs;
`endif

    assign sample  = (tick_q == T_SAMPLE);
    assign bit_end = (tick_q == T_LAST);
    assign par_exp = par_type_q ? ~^shift_q : ^shift_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        tick_d     = bit_end ? '0 : tick_q + 1'b1;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        dout_d     = data_out;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (rxs_d && !rxs) begin
                    state_d    = START;
                    bitcnt_d   = '0;
                    perr_d     = 1'b0;
                    par_en_d   = parity_en;
                    par_type_d = parity_type;
                end
            end
            START: begin
                if (sample && bit_val) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (sample) shift_d = {bit_val, shift_q[DWIDTH-1:1]};
                if (bit_end) begin
                    if (bitcnt_q == B_LAST) state_d = par_en_q ? PARITY : STOP;
                    else bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (sample) perr_d = (bit_val != par_exp);
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Resolving mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (sample) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    if (bit_val && !perr_q) begin
                        dout_d = shift_q;
                        dv_d   = 1'b1;
                    end else if (bit_val) begin
                        pe_d = 1'b1;
                    end else begin
                        se_d = 1'b1;
                        pe_d = perr_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            par_en_q     <= par_en_d;
            par_type_q   <= par_type_d;
            data_out     <= dout_d;
            data_valid   <= dv_d;
            parity_error <= pe_d;
            stop_error   <= se_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of single frames plus hand-written
// false-start, back-to-back, mid-frame reset and (optionally) majority-vote sequences.
module tb_uart_rx_frame;

    localparam int DW = 8;
    localparam int OV = 8;
    localparam int LAT = 2 + OV / 2 + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_in = 1'b1;
    logic          parity_en = 1'b0;
    logic          parity_type = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid, parity_error, stop_error, busy;

    uart_rx_frame #(.DWIDTH(DW), .OVERSAMPLE(OV)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in),
        .parity_en(parity_en), .parity_type(parity_type),
        .data_out(data_out), .data_valid(data_valid),
        .parity_error(parity_error), .stop_error(stop_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0, busy_cnt = 0, dv_cyc = 0;
    logic [DW-1:0] dq[$];
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
            dq.push_back(data_out);
        end
        if (parity_error) pe_cnt = pe_cnt + 1;
        if (stop_error) se_cnt = se_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    int n_cmp = 0, n_bad = 0;
    int stop_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx_in = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit, input logic sbit);
        drive(1'b0, OV);
        for (int i = 0; i < DW; i++) drive(d[i], OV);
        if (pen) drive(pbit, OV);
        stop_cyc = cyc;
        drive(sbit, OV);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          par_en;
        logic          par_type;
        logic          par_bit;
        logic          stop_bit;
        int            exp_dv;
        int            exp_pe;
        int            exp_se;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, p0, s0, b0, q0;

        //            data   pen   ptyp  pbit  stop  dv pe se dout
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'hC8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'hC8};
        vecs[2] = '{8'hC8, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 0, 8'hC8};
        vecs[3] = '{8'hC9, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1, 8'hC8};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 0, 8'h3C};
        vecs[5] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 1, 8'h3C};

        // Reset held while the line toggles
        for (int i = 0; i < 12; i++) drive(i[0], 1);
        check("reset_outputs", {data_out, data_valid, parity_error, stop_error, busy}, '0);
        rx_in = 1'b1;
        rst = 1'b1;
        drive(1'b1, 3 * OV);
        check("idle_no_pulses", dv_cnt + pe_cnt + se_cnt, 0);
        check("idle_busy", busy, 1'b0);

        for (int v = 0; v < 6; v++) begin
            parity_en   = vecs[v].par_en;
            parity_type = vecs[v].par_type;
            d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
            send_frame(vecs[v].data, vecs[v].par_en, vecs[v].par_bit, vecs[v].stop_bit);
            drive(1'b1, 2 * OV);
            check($sformatf("v%0d_data_valid", v), dv_cnt - d0, vecs[v].exp_dv);
            check($sformatf("v%0d_parity_error", v), pe_cnt - p0, vecs[v].exp_pe);
            check($sformatf("v%0d_stop_error", v), se_cnt - s0, vecs[v].exp_se);
            check($sformatf("v%0d_data_out", v), data_out, vecs[v].exp_dout);
            check($sformatf("v%0d_busy", v), busy, 1'b0);
            if (vecs[v].exp_dv == 1)
                check($sformatf("v%0d_latency", v), dv_cyc - stop_cyc, LAT);
        end

        // Parity settings changed after the start bit must not affect this frame
        parity_en = 1'b0; parity_type = 1'b0;
        d0 = dv_cnt; p0 = pe_cnt;
        drive(1'b0, OV);
        parity_en = 1'b1; parity_type = 1'b1;
        for (int i = 0; i < DW; i++) drive((i == 0) || (i == 7), OV);
        drive(1'b1, 3 * OV);
        check("midframe_cfg_dv", dv_cnt - d0, 1);
        check("midframe_cfg_pe", pe_cnt - p0, 0);
        check("midframe_cfg_data", data_out, 8'h81);
        parity_en = 1'b0; parity_type = 1'b0;

        // Short low glitch: false start
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt; b0 = busy_cnt;
        drive(1'b0, OV / 2 - 2);
        drive(1'b1, 3 * OV);
        check("glitch_busy_rose", busy_cnt > b0, 1);
        check("glitch_busy_dropped", busy, 1'b0);
        check("glitch_no_pulses", (dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0), 0);
        check("glitch_data_out", data_out, 8'h81);

`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-cycle high spike at the sample point of data bit 3 of 8'h00
        d0 = dv_cnt;
        drive(1'b0, OV);
        for (int i = 0; i < 3; i++) drive(1'b0, OV);
        drive(1'b0, OV / 2);
        drive(1'b1, 1);
        drive(1'b0, OV / 2 - 1);
        for (int i = 4; i < DW; i++) drive(1'b0, OV);
        drive(1'b1, 3 * OV);
        check("vote_dv", dv_cnt - d0, 1);
        check("vote_data_out", data_out, 8'h00);
`endif

        // Back-to-back frames with no idle gap
        d0 = dv_cnt; q0 = dq.size();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2 * OV);
        check("b2b_count", dv_cnt - d0, 2);
        if (dq.size() >= q0 + 2) begin
            check("b2b_first", dq[q0], 8'h12);
            check("b2b_second", dq[q0 + 1], 8'h34);
        end else begin
            check("b2b_queue_depth", dq.size() - q0, 2);
        end

        // Reset in the middle of a third frame
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        drive(1'b0, OV);
        drive(1'b1, OV);
        drive(1'b0, 3);
        check("rst_mid_busy_before", busy, 1'b1);
        rst = 1'b0;
        drive(1'b0, 2);
        check("rst_mid_outputs", {data_out, data_valid, parity_error, stop_error, busy}, '0);
        rx_in = 1'b1;
        rst = 1'b1;
        drive(1'b1, 3 * OV);
        check("rst_mid_no_pulses", (dv_cnt - d0) + (pe_cnt - p0) + (se_cnt - s0), 0);
        check("rst_mid_data_out", data_out, 8'h00);
        check("rst_mid_busy_after", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
